// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered ALU execute stage with control decode, zero flag and branch resolution.
// Optional SLL/SRL decode when ALU_EXEC_SHIFT_EN is defined.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        alu_op,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              branch,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic              take_branch
);
  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_SLL = 4'b1000;
  localparam logic [3:0] C_SRL = 4'b1001;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_INV = 4'b1111;
  logic [3:0]        ctrl_d;
  logic [3:0]        rtype_ctrl;
  logic [DATA_W-1:0] res_d;
  logic              slt;
  logic              zero_d;
`ifndef ALU_EXEC_SHIFT_EN
  logic unused_shamt;
  assign unused_shamt = ^shamt;
`endif
  assign slt = $signed(operand_a) < $signed(operand_b);
  always_comb begin
    rtype_ctrl = funct == 6'b100000 ? C_ADD :
                 funct == 6'b100010 ? C_SUB :
                 funct == 6'b100100 ? C_AND :
                 funct == 6'b100101 ? C_OR  :
                 funct == 6'b101010 ? C_SLT :
                 funct == 6'b100111 ? C_NOR :
`ifdef ALU_EXEC_SHIFT_EN
                 funct == 6'b000000 ? C_SLL :
                 funct == 6'b000010 ? C_SRL :
`endif
                 C_INV;
    ctrl_d = alu_op == 2'b01 ? C_SUB :
             alu_op == 2'b10 ? rtype_ctrl : C_ADD;
    res_d = ctrl_d == C_ADD ? operand_a + operand_b :
            ctrl_d == C_SUB ? operand_a - operand_b :
            ctrl_d == C_AND ? operand_a & operand_b :
            ctrl_d == C_OR  ? operand_a | operand_b :
            ctrl_d == C_NOR ? ~(operand_a | operand_b) :
            ctrl_d == C_SLT ? {{(DATA_W-1){1'b0}}, slt} :
`ifdef ALU_EXEC_SHIFT_EN
            ctrl_d == C_SLL ? operand_b << shamt :
            ctrl_d == C_SRL ? operand_b >> shamt :
`endif
            '0;
    zero_d = res_d == '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_ctrl    <= '0;
      alu_result  <= '0;
      zero        <= 1'b0;
      take_branch <= 1'b0;
    end else begin
      alu_ctrl    <= ctrl_d;
      alu_result  <= res_d;
      zero        <= zero_d;
      take_branch <= branch & zero_d;
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: table-driven directed checks of alu_exec_unit plus reset and hold sequences.
module tb_alu_exec_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_a, operand_b;
  logic        branch;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero, take_branch;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [5:0]  f;
    logic [4:0]  sh;
    logic [31:0] a, b;
    logic        br;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z, t;
  } vec_t;

`ifdef ALU_EXEC_SHIFT_EN
  localparam bit SH = 1'b1;
`else
  localparam bit SH = 1'b0;
`endif

  vec_t v[18];

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .alu_op(alu_op), .funct(funct), .shamt(shamt),
    .operand_a(operand_a), .operand_b(operand_b), .branch(branch),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero), .take_branch(take_branch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
    end
  endtask

  task automatic chk_all(input string n, input logic [3:0] c, input logic [31:0] r, input logic z, input logic t);
    chk({n, ".ctrl"}, {28'd0, alu_ctrl}, {28'd0, c});
    chk({n, ".result"}, alu_result, r);
    chk({n, ".zero"}, {31'd0, zero}, {31'd0, z});
    chk({n, ".take"}, {31'd0, take_branch}, {31'd0, t});
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] a, input logic [31:0] b, input logic br);
    alu_op = op; funct = f; shamt = sh; operand_a = a; operand_b = b; branch = br;
  endtask

  initial begin
    v[0]  = '{"add",      2'b10, 6'h20, 5'd0,  32'hC, 32'hA, 1'b0, 4'b0010, 32'h16, 1'b0, 1'b0};
    v[1]  = '{"sub",      2'b10, 6'h22, 5'd0,  32'hC, 32'hA, 1'b0, 4'b0110, 32'h2,  1'b0, 1'b0};
    v[2]  = '{"and",      2'b10, 6'h24, 5'd0,  32'hC, 32'hA, 1'b0, 4'b0000, 32'h8,  1'b0, 1'b0};
    v[3]  = '{"or",       2'b10, 6'h25, 5'd0,  32'hC, 32'hA, 1'b0, 4'b0001, 32'hE,  1'b0, 1'b0};
    v[4]  = '{"nor",      2'b10, 6'h27, 5'd0,  32'hC, 32'hA, 1'b0, 4'b1100, 32'hFFFFFFF1, 1'b0, 1'b0};
    v[5]  = '{"slt0",     2'b10, 6'h2A, 5'd0,  32'hC, 32'hA, 1'b0, 4'b0111, 32'h0,  1'b1, 1'b0};
    v[6]  = '{"slt_neg",  2'b10, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'h1, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0};
    v[7]  = '{"beq_take", 2'b01, 6'h3F, 5'd0,  32'h1234, 32'h1234, 1'b1, 4'b0110, 32'h0, 1'b1, 1'b1};
    v[8]  = '{"beq_ne",   2'b01, 6'h00, 5'd0,  32'h1235, 32'h1234, 1'b1, 4'b0110, 32'h1, 1'b0, 1'b0};
    v[9]  = '{"beq_nobr", 2'b01, 6'h20, 5'd0,  32'h1234, 32'h1234, 1'b0, 4'b0110, 32'h0, 1'b1, 1'b0};
    v[10] = '{"invalid",  2'b10, 6'h3F, 5'd0,  32'h5, 32'h3, 1'b1, 4'b1111, 32'h0, 1'b1, 1'b1};
    v[11] = '{"add_ovf",  2'b00, 6'h00, 5'd0,  32'h7FFFFFFF, 32'h1, 1'b0, 4'b0010, 32'h80000000, 1'b0, 1'b0};
    v[12] = '{"sub_wrap", 2'b01, 6'h00, 5'd0,  32'h0, 32'h1, 1'b0, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0};
    v[13] = '{"slt_min",  2'b10, 6'h2A, 5'd0,  32'h80000000, 32'h1, 1'b0, 4'b0111, 32'h1, 1'b0, 1'b0};
    v[14] = '{"op11_add", 2'b11, 6'h24, 5'd9,  32'h3, 32'h4, 1'b0, 4'b0010, 32'h7, 1'b0, 1'b0};
    v[15] = '{"op00_add", 2'b00, 6'h24, 5'd0,  32'h1, 32'h1, 1'b1, 4'b0010, 32'h2, 1'b0, 1'b0};
    v[16] = '{"sll", 2'b10, 6'h00, 5'd4, 32'h0, 32'hF, 1'b0,
              SH ? 4'b1000 : 4'b1111, SH ? 32'hF0 : 32'h0, !SH, 1'b0};
    v[17] = '{"srl", 2'b10, 6'h02, 5'd31, 32'h0, 32'h80000000, 1'b0,
              SH ? 4'b1001 : 4'b1111, SH ? 32'h1 : 32'h0, !SH, 1'b0};

    rst = 1'b0;
    drive(2'b00, 6'h0, 5'd0, 32'h5, 32'h7, 1'b0);
    #2;
    chk_all("reset_init", 4'b0000, 32'h0, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all("first_after_reset", 4'b0010, 32'd12, 1'b0, 1'b0);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive(v[i].op, v[i].f, v[i].sh, v[i].a, v[i].b, v[i].br);
      @(posedge clk); #1;
      chk_all(v[i].name, v[i].ctrl, v[i].res, v[i].z, v[i].t);
      drive(2'b10, 6'h25, 5'd3, $urandom, $urandom, 1'b1);
      #2;
      chk({v[i].name, ".hold"}, alu_result, v[i].res);
    end

    @(negedge clk);
    drive(2'b10, 6'h25, 5'd0, 32'hF0, 32'h0F, 1'b0);
    @(posedge clk); #1;
    chk_all("pre_reset", 4'b0001, 32'hFF, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("async_reset", 4'b0000, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_held", 4'b0000, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b00, 6'h0, 5'd0, 32'h5, 32'h7, 1'b0);
    @(posedge clk); #1;
    chk_all("release", 4'b0010, 32'd12, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter: DATA_W, default 32, operand/result width; the unit SHALL be verified at 32.
REQ-002 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  asynchronous active-low reset.
REQ-005 Port: alu_op  in  2  main-control ALU opcode.
REQ-006 Port: funct  in  6  instruction[5:0].
REQ-007 Port: shamt  in  5  instruction[10:6], used only for shift operations.
REQ-008 Port: operand_a  in  DATA_W  register-file read data 1.
REQ-009 Port: operand_b  in  DATA_W  second operand: read data 2 or sign-extended immediate.
REQ-010 Port: branch  in  1  main-control Branch flag.
REQ-011 Port: alu_ctrl  out  4  decoded ALU control code, registered.
REQ-012 Port: alu_result  out  DATA_W  registered result.
REQ-013 Port: zero  out  1  registered; 1 when the computed result is all zeros.
REQ-014 Port: take_branch  out  1  registered branch AND zero.

Function
REQ-015 Decode SHALL be combinational with this mapping:
- alu_op 00 -> 0010 (ADD).
- alu_op 01 -> 0110 (SUB).
- alu_op 11 -> 0010 (ADD).
- alu_op 10 -> by funct: 100000 -> 0010 ADD; 100010 -> 0110 SUB; 100100 -> 0000 AND; 100101 -> 0001 OR; 101010 -> 0111 SLT; 100111 -> 1100 NOR.
- alu_op 10 with any other funct -> 1111 (INVALID).
REQ-016 Operations:
- ADD/SUB: two's complement modulo 2^DATA_W; carry and overflow are discarded.
- AND, OR, NOR: bitwise.
- SLT: signed compare; result is 1 when operand_a < operand_b, else 0.
- INVALID: result 0.
REQ-017 zero SHALL be derived from the same-cycle result and SHALL be 1 for INVALID.
REQ-018 take_branch SHALL equal branch AND zero, both from the same cycle's inputs.
REQ-019 Timing:
- All inputs are sampled on the rising edge of clk.
- alu_ctrl, alu_result, zero and take_branch SHALL update together, exactly 1 cycle after sampling.
- Throughput is one operation per cycle; there is no handshake or stall.
REQ-020 Outputs SHALL hold their value between edges, whatever the inputs do.
REQ-021 Boundaries:
- 0x7FFFFFFF+1 SHALL give 0x80000000.
- 0x00000000-1 SHALL give 0xFFFFFFFF.
- SLT 0x80000000 vs 0x00000001 SHALL give 1.

Reset
REQ-022 While rst=0, all outputs SHALL be 0, asynchronously, including in the middle of an operation.
REQ-023 On rst release, the first rising edge with rst=1 SHALL produce a valid result.

Configuration
REQ-024 Macro: ALU_EXEC_SHIFT_EN.
- When defined, alu_op 10 with funct 000000 SHALL decode to 1000 (SLL: operand_b << shamt, zero fill).
- When defined, alu_op 10 with funct 000010 SHALL decode to 1001 (SRL: operand_b >> shamt, logical).
- When not defined, both funct codes SHALL decode to INVALID and shamt SHALL be ignored.
- The port list SHALL be identical in both builds.

Verification
REQ-025 Reset: rst=0 mid-stream -> all outputs 0 immediately; release, alu_op=00, a=5, b=7 -> next edge alu_result=12, alu_ctrl=0010.
REQ-026 R-type sweep with a=0x0000000C, b=0x0000000A:
- ADD -> 0x16; SUB -> 0x2; AND -> 0x8; OR -> 0xE; NOR -> 0xFFFFFFF1.
- SLT -> 0; SLT with a=0xFFFFFFFF, b=1 -> 1.
REQ-027 Branch: alu_op=01, branch=1, a=b=0x1234 -> zero=1, take_branch=1; with a=0x1235 -> zero=0, take_branch=0; branch=0 -> take_branch=0.
REQ-028 Invalid funct 111111 with alu_op=10 -> alu_ctrl=1111, alu_result=0, zero=1.
REQ-029 Back-to-back ops on consecutive cycles -> each result appears exactly 1 cycle after its inputs, with no bubbles.
REQ-030 With ALU_EXEC_SHIFT_EN: funct=000000, shamt=4, b=0x0000000F -> 0x000000F0; funct=000010, shamt=31, b=0x80000000 -> 1. Without the macro, both funct codes -> alu_ctrl=1111.
